// File: rtl/gray_counter_updn.sv
// Up/down binary counter with a registered Gray-coded copy and a wrap pulse.
// Gray is encoded from the next-state binary so the output flop never glitches.
module gray_counter_updn #(
    parameter int          WIDTH    = 4,
    parameter int unsigned INIT_BIN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT_BIN);
    localparam logic [WIDTH-1:0] INIT_G = INIT_B ^ (INIT_B >> 1);
    localparam logic [WIDTH-1:0] ONES   = '1;

    logic [WIDTH-1:0] bin_nx;
    logic             wrap_nx;

    always_comb begin
        bin_nx  = bin;
        wrap_nx = 1'b0;
        if (load) begin
            bin_nx = load_bin;
        end else if (en) begin
            if (up) begin
                bin_nx  = bin + 1'b1;
                wrap_nx = (bin == ONES);
            end else begin
                bin_nx  = bin - 1'b1;
                wrap_nx = (bin == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= INIT_B;
            gray <= INIT_G;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nx;
            gray <= bin_nx ^ (bin_nx >> 1);
            wrap <= wrap_nx;
        end
    end

endmodule

// File: tb/tb_gray_counter_updn.sv
// Scoreboard bench: four counter variants share one control stream; a modular
// arithmetic model predicts each cycle and a monitor compares after every edge.
module tb_gray_counter_updn;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [7:0] load_bin;

    always #5 clk = ~clk;

    logic [3:0] b4a, g4a, b4b, g4b;
    logic [7:0] b8, g8;
    logic [0:0] b1, g1;
    logic       w4a, w4b, w8, w1;

    gray_counter_updn #(.WIDTH(4), .INIT_BIN(0)) u4a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin[3:0]), .bin(b4a), .gray(g4a), .wrap(w4a));
    gray_counter_updn #(.WIDTH(4), .INIT_BIN(5)) u4b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin[3:0]), .bin(b4b), .gray(g4b), .wrap(w4b));
    gray_counter_updn #(.WIDTH(8), .INIT_BIN(0)) u8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .bin(b8), .gray(g8), .wrap(w8));
    gray_counter_updn #(.WIDTH(1), .INIT_BIN(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin[0:0]), .bin(b1), .gray(g1), .wrap(w1));

    logic [3:0][7:0] obin, ogray;
    logic [3:0]      owrap;
    assign obin  = {8'(b1), b8, 8'(b4b), 8'(b4a)};
    assign ogray = {8'(g1), g8, 8'(g4b), 8'(g4a)};
    assign owrap = {w1, w8, w4b, w4a};

    typedef struct packed {
        logic [3:0][7:0] bin;
        logic [3:0]      wrap;
        logic            step;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    localparam int WS[4] = '{4, 4, 8, 1};
    localparam int IV[4] = '{0, 5, 0, 0};
    int mb[4];

    // Reference: plain modular arithmetic per variant, result queued per cycle.
    task automatic drive(input logic r, input logic l, input logic [7:0] lb,
                         input logic e, input logic u);
        exp_t x;
        @(negedge clk);
        rst = r; load = l; load_bin = lb; en = e; up = u;
        x = '0;
        x.step = !r && !l && e;
        for (int i = 0; i < 4; i++) begin
            int m;
            m = 1 << WS[i];
            if (r) begin
                mb[i] = IV[i] % m;
            end else if (l) begin
                mb[i] = int'(lb) % m;
            end else if (e) begin
                if (u) begin
                    x.wrap[i] = (mb[i] == m - 1);
                    mb[i] = (mb[i] + 1) % m;
                end else begin
                    x.wrap[i] = (mb[i] == 0);
                    mb[i] = (mb[i] + m - 1) % m;
                end
            end
            x.bin[i] = 8'(mb[i]);
        end
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0][7:0] pg;
        logic [7:0] eg;
        pg = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    eg = e.bin[i] ^ (e.bin[i] >> 1);
                    checks++;
                    if (obin[i] !== e.bin[i] || ogray[i] !== eg || owrap[i] !== e.wrap[i]) begin
                        fails++;
                        $display("FAIL dut%0d outputs: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                                 i, obin[i], ogray[i], owrap[i], e.bin[i], eg, e.wrap[i]);
                    end
                    if (e.step) begin
                        checks++;
                        if ($countones(ogray[i] ^ pg[i]) != 1) begin
                            fails++;
                            $display("FAIL dut%0d gray_one_bit: got %h -> %h, want exactly one bit change",
                                     i, pg[i], ogray[i]);
                        end
                    end
                    pg[i] = ogray[i];
                end
            end
        end
    end

    initial begin : stim
        int n;
        for (int i = 0; i < 4; i++) mb[i] = 0;
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
        // reset, then a full upward lap (wrap on the 16th step for width 4)
        drive(1, 0, 8'h00, 0, 0);
        for (int k = 0; k < 16; k++) drive(0, 0, 8'h00, 1, 1);
        // down across zero, then one more
        drive(0, 0, 8'h00, 1, 0);
        drive(0, 0, 8'h00, 1, 0);
        // load beats enable, then hold
        drive(0, 1, 8'h0A, 1, 1);
        drive(0, 0, 8'h0A, 0, 1);
        drive(0, 0, 8'h0A, 0, 0);
        // reset beats load while counting from 0111
        drive(0, 1, 8'h07, 0, 1);
        drive(0, 0, 8'h00, 1, 1);
        drive(0, 1, 8'hF3, 1, 1);
        drive(1, 1, 8'h3C, 1, 1);
        drive(0, 0, 8'h00, 1, 1);
        // direction flips every cycle
        for (int k = 0; k < 8; k++) drive(0, 0, 8'h00, 1, k[0]);
        // random soak
        for (int k = 0; k < 10000; k++) begin
            n = $urandom_range(0, 99);
            drive(n < 1, (n >= 1 && n < 6), 8'($urandom), ($urandom_range(0, 9) < 7),
                  1'($urandom));
        end
        drive(0, 0, 8'h00, 0, 0);
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
